// File: rtl/fir_coeff_loader_pkg.sv
// Shared definitions for the FIR coefficient loader.
// Holds the FSM states, the control/status register bit map and the status packer.
package fir_coeff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_B0     = 2'd1,
        ST_WR_B1     = 2'd2,
        ST_WAIT_SYNC = 2'd3
    } state_e;

    localparam int CTRL_LOAD_BIT   = 31;
    localparam int CTRL_COMMIT_BIT = 30;
    localparam int CTRL_CLR_BIT    = 29;
    localparam int CTRL_IDX_W      = 8;

    localparam int STAT_BUSY_BIT    = 31;
    localparam int STAT_PEND_BIT    = 30;
    localparam int STAT_OVERRUN_BIT = 29;
    localparam int STAT_RANGE_BIT   = 28;
    localparam int STAT_COUNT_W     = 16;

    function automatic logic [31:0] pack_status(
        input logic                    busy,
        input logic                    pending,
        input logic                    overrun,
        input logic                    range_err,
        input logic [STAT_COUNT_W-1:0] load_count
    );
        logic [31:0] s;
        s                   = '0;
        s[STAT_BUSY_BIT]    = busy;
        s[STAT_PEND_BIT]    = pending;
        s[STAT_OVERRUN_BIT] = overrun;
        s[STAT_RANGE_BIT]   = range_err;
        s[STAT_COUNT_W-1:0] = load_count;
        return s;
    endfunction

endpackage

// File: rtl/fir_coeff_loader_toggle_detect.sv
// Turns software toggle bits into one-cycle event pulses.
// The first cycle out of reset only captures the register value so stale toggles never fire.
module toggle_detect #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] bits_i,
    output logic [W-1:0] event_o
);

    logic [W-1:0] copy_q;
    logic         armed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            copy_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            copy_q  <= bits_i;
            armed_q <= 1'b1;
        end
    end

    assign event_o = armed_q ? (bits_i ^ copy_q) : '0;

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads b0/b1 coefficient pairs into the shadow bank of a double-buffered FIR
// coefficient RAM and swaps banks on a frame boundary after a commit request.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int NTAPS  = 32,
    parameter int COEF_W = 16
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    input  logic [2*COEF_W-1:0]     coef_data,
    input  logic [31:0]             coef_ctrl,
    input  logic                    sync_in,
    output logic                    coef_we,
    output logic [$clog2(NTAPS):0]  coef_addr,
    output logic [COEF_W-1:0]       coef_wdata,
    output logic                    active_bank,
    output logic [31:0]             status_out,
    output state_e                  dbg_state_o
);

    localparam int TAP_W = $clog2(NTAPS);
    localparam int PAIR_W = TAP_W - 1;

    logic [2:0] ev;
    logic       load_ev;
    logic       commit_ev;
    logic       clr_ev;

    toggle_detect #(.W(3)) u_toggle (
        .clk_i   (user_clk),
        .rst_n_i (user_rst_n),
        .bits_i  ({coef_ctrl[CTRL_LOAD_BIT], coef_ctrl[CTRL_COMMIT_BIT], coef_ctrl[CTRL_CLR_BIT]}),
        .event_o (ev)
    );

    assign load_ev   = ev[2];
    assign commit_ev = ev[1];
    assign clr_ev    = ev[0];

    state_e                    state_q, state_d;
    logic [COEF_W-1:0]         b1_q, b1_d;
    logic [PAIR_W-1:0]         idx_q, idx_d;
    logic                      we_q, we_d;
    logic [TAP_W:0]            addr_q, addr_d;
    logic [COEF_W-1:0]         wdata_q, wdata_d;
    logic                      bank_q, bank_d;
    logic                      pend_q, pend_d;
    logic                      over_q, over_d;
    logic                      range_q, range_d;
    logic [STAT_COUNT_W-1:0]   count_q, count_d;

    logic set_over;
    logic set_range;
    logic flip;
    logic idx_ok;
    logic unused_ctrl_bits;

    assign idx_ok = ({24'd0, coef_ctrl[CTRL_IDX_W-1:0]} < 32'(NTAPS / 2));
    assign unused_ctrl_bits = ^coef_ctrl[CTRL_CLR_BIT-1:CTRL_IDX_W];

    always_comb begin
        state_d   = state_q;
        b1_d      = b1_q;
        idx_d     = idx_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bank_d    = bank_q;
        count_d   = count_q;
        set_over  = 1'b0;
        set_range = 1'b0;
        flip      = 1'b0;

        // Write strobes are computed one state ahead so the RAM port comes straight from flops.
        case (state_q)
            ST_IDLE: begin
                if (load_ev && idx_ok) begin
                    state_d = ST_WR_B0;
                    b1_d    = coef_data[COEF_W-1:0];
                    idx_d   = coef_ctrl[PAIR_W-1:0];
                    we_d    = 1'b1;
                    addr_d  = {~bank_q, coef_ctrl[PAIR_W-1:0], 1'b0};
                    wdata_d = coef_data[2*COEF_W-1:COEF_W];
                end else begin
                    set_range = load_ev;
                    if (commit_ev || pend_q) begin
                        state_d = ST_WAIT_SYNC;
                    end
                end
            end
            ST_WR_B0: begin
                set_over = load_ev;
                state_d  = ST_WR_B1;
                we_d     = 1'b1;
                addr_d   = {~bank_q, idx_q, 1'b1};
                wdata_d  = b1_q;
                count_d  = count_q + 1'b1;
            end
            ST_WR_B1: begin
                set_over = load_ev;
                state_d  = (commit_ev || pend_q) ? ST_WAIT_SYNC : ST_IDLE;
            end
            ST_WAIT_SYNC: begin
                set_over = load_ev;
                if (sync_in) begin
                    flip    = 1'b1;
                    bank_d  = ~bank_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d  = (pend_q & ~flip) | commit_ev;
        over_d  = (over_q & ~clr_ev) | set_over;
        range_d = (range_q & ~clr_ev) | set_range;
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q <= ST_IDLE;
            b1_q    <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            over_q  <= 1'b0;
            range_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            over_q  <= over_d;
            range_q <= range_d;
            count_q <= count_d;
        end
    end

    assign coef_we     = we_q;
    assign coef_addr   = addr_q;
    assign coef_wdata  = wdata_q;
    assign active_bank = bank_q;
    assign dbg_state_o = state_q;
    assign status_out  = pack_status(state_q != ST_IDLE, pend_q, over_q, range_q, count_q);

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed corner sequences, a load vector table,
// and randomized transactions checked against a transaction-level model.
module tb_fir_coeff_loader;
    import fir_coeff_loader_pkg::*;

    localparam int NTAPS = 32;
    localparam int W     = 22;

    logic        clk;
    logic        rst_n;
    logic [31:0] coef_data;
    logic [31:0] coef_ctrl;
    logic        sync_in;
    logic        coef_we;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        active_bank;
    logic [31:0] status_out;
    state_e      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic         mon_en = 1'b0;

    fir_coeff_loader #(.NTAPS(NTAPS), .COEF_W(16)) dut (
        .user_clk    (clk),
        .user_rst_n  (rst_n),
        .coef_data   (coef_data),
        .coef_ctrl   (coef_ctrl),
        .sync_in     (sync_in),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .active_bank (active_bank),
        .status_out  (status_out),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every cycle passes through here, so the write scoreboard sees every RAM write.
    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (mon_en && coef_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd_unexpected_write: got addr 0x%0h data 0x%0h expected none", coef_addr, coef_wdata);
            end else begin
                e = exp_q.pop_front();
                check("rnd_write", {10'd0, coef_addr, coef_wdata}, {10'd0, e});
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        coef_ctrl = '0;
        coef_data = '0;
        sync_in   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
        logic        err;
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[7];

    int unsigned m_bank, m_count, m_range, m_over;

    initial begin
        vecs[0] = '{8'd0,   32'hCAFEF00D, 1'b0, 6'h20, 6'h21, 16'hCAFE, 16'hF00D, 16'd1};
        vecs[1] = '{8'd15,  32'h00018000, 1'b0, 6'h3E, 6'h3F, 16'h0001, 16'h8000, 16'd2};
        vecs[2] = '{8'd7,   32'hFFFF0000, 1'b0, 6'h2E, 6'h2F, 16'hFFFF, 16'h0000, 16'd3};
        vecs[3] = '{8'd16,  32'h12345678, 1'b1, 6'h00, 6'h00, 16'h0000, 16'h0000, 16'd3};
        vecs[4] = '{8'd9,   32'h5A5AA5A5, 1'b0, 6'h32, 6'h33, 16'h5A5A, 16'hA5A5, 16'd4};
        vecs[5] = '{8'd255, 32'h87654321, 1'b1, 6'h00, 6'h00, 16'h0000, 16'h0000, 16'd4};
        vecs[6] = '{8'd1,   32'h0000FFFF, 1'b0, 6'h22, 6'h23, 16'h0000, 16'hFFFF, 16'd5};

        // Basic load, including reset values seen while held in reset.
        rst_n = 1'b0; coef_ctrl = '0; coef_data = '0; sync_in = 1'b0;
        tick(); tick();
        check("rst_we", {31'd0, coef_we}, 32'd0);
        check("rst_addr", {26'd0, coef_addr}, 32'd0);
        check("rst_wdata", {16'd0, coef_wdata}, 32'd0);
        check("rst_bank", {31'd0, active_bank}, 32'd0);
        check("rst_status", status_out, 32'd0);
        rst_n = 1'b1;
        tick();
        coef_ctrl = 32'h80000003; coef_data = 32'h12345678;
        tick();
        check("s1_we0", {31'd0, coef_we}, 32'd1);
        check("s1_addr0", {26'd0, coef_addr}, 32'h26);
        check("s1_wdata0", {16'd0, coef_wdata}, 32'h1234);
        tick();
        check("s1_we1", {31'd0, coef_we}, 32'd1);
        check("s1_addr1", {26'd0, coef_addr}, 32'h27);
        check("s1_wdata1", {16'd0, coef_wdata}, 32'h5678);
        check("s1_status", status_out, 32'h80000001);
        tick();
        check("s1_we_off", {31'd0, coef_we}, 32'd0);
        check("s1_addr_hold", {26'd0, coef_addr}, 32'h27);
        check("s1_wdata_hold", {16'd0, coef_wdata}, 32'h5678);
        check("s1_idle", status_out, 32'h00000001);

        // Commit, sync ten cycles later, then a load lands in the other bank.
        coef_ctrl = 32'hC0000003;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s2_busy_wait", status_out, 32'hC0000001);
            check("s2_bank_wait", {31'd0, active_bank}, 32'd0);
        end
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("s2_bank_flip", {31'd0, active_bank}, 32'd1);
        check("s2_status", status_out, 32'h00000001);
        coef_ctrl = 32'h40000003; coef_data = 32'hAAAA5555;
        tick();
        check("s2_addr0", {26'd0, coef_addr}, 32'h06);
        check("s2_wdata0", {16'd0, coef_wdata}, 32'hAAAA);
        tick();
        check("s2_addr1", {26'd0, coef_addr}, 32'h07);
        tick();

        // Load and commit together; early sync during writes must not flip.
        do_reset();
        coef_ctrl = 32'hC0000001; coef_data = 32'hBEEF0001;
        tick();
        check("s3_addr0", {26'd0, coef_addr}, 32'h22);
        check("s3_status0", status_out, 32'hC0000000);
        sync_in = 1'b1;
        tick();
        check("s3_we1", {31'd0, coef_we}, 32'd1);
        check("s3_addr1", {26'd0, coef_addr}, 32'h23);
        check("s3_wdata1", {16'd0, coef_wdata}, 32'h0001);
        tick();
        sync_in = 1'b0;
        check("s3_state", {30'd0, dbg_state}, {30'd0, ST_WAIT_SYNC});
        check("s3_bank_hold", {31'd0, active_bank}, 32'd0);
        check("s3_we_off", {31'd0, coef_we}, 32'd0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("s3_bank_flip", {31'd0, active_bank}, 32'd1);
        check("s3_status", status_out, 32'h00000001);

        // Out-of-range index and clearing the error.
        do_reset();
        coef_ctrl = 32'h80000010; coef_data = 32'h12345678;
        tick();
        check("s4_we", {31'd0, coef_we}, 32'd0);
        check("s4_range", status_out, 32'h10000000);
        tick();
        check("s4_we2", {31'd0, coef_we}, 32'd0);
        coef_ctrl = 32'hA0000010;
        tick();
        check("s4_cleared", status_out, 32'h00000000);

        // Second load toggle during WR_B0 is an overrun.
        do_reset();
        coef_ctrl = 32'h80000002; coef_data = 32'h11112222;
        tick();
        check("s5_addr0", {26'd0, coef_addr}, 32'h24);
        coef_ctrl = 32'h00000002;
        tick();
        check("s5_addr1", {26'd0, coef_addr}, 32'h25);
        check("s5_overrun", status_out, 32'hA0000001);
        tick();
        check("s5_we_off", {31'd0, coef_we}, 32'd0);
        tick();
        check("s5_no_second_pair", {31'd0, coef_we}, 32'd0);
        check("s5_status", status_out, 32'h20000001);

        // Reset in WR_B0 drops the second write.
        do_reset();
        coef_ctrl = 32'h80000002;
        tick();
        check("s6_we", {31'd0, coef_we}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("s6_we_rst", {31'd0, coef_we}, 32'd0);
        check("s6_status", status_out, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("s6_we_after", {31'd0, coef_we}, 32'd0);
        check("s6_count_after", status_out, 32'd0);

        // Reset in WAIT_SYNC cancels the commit.
        do_reset();
        coef_ctrl = 32'h40000000;
        tick();
        check("s7_wait", status_out, 32'hC0000000);
        rst_n = 1'b0; sync_in = 1'b1;
        tick();
        check("s7_bank", {31'd0, active_bank}, 32'd0);
        check("s7_status", status_out, 32'd0);
        sync_in = 1'b0; rst_n = 1'b1;
        tick();
        tick();
        check("s7_bank_after", {31'd0, active_bank}, 32'd0);

        // Table of single loads into bank 1.
        do_reset();
        foreach (vecs[k]) begin
            coef_ctrl = {~coef_ctrl[31], coef_ctrl[30:8], vecs[k].idx};
            coef_data = vecs[k].data;
            tick();
            if (!vecs[k].err) begin
                check("tbl_we0", {31'd0, coef_we}, 32'd1);
                check("tbl_addr0", {26'd0, coef_addr}, {26'd0, vecs[k].a0});
                check("tbl_wdata0", {16'd0, coef_wdata}, {16'd0, vecs[k].w0});
                tick();
                check("tbl_addr1", {26'd0, coef_addr}, {26'd0, vecs[k].a1});
                check("tbl_wdata1", {16'd0, coef_wdata}, {16'd0, vecs[k].w1});
                tick();
                check("tbl_status", status_out, {16'd0, vecs[k].cnt});
            end else begin
                check("tbl_err_we", {31'd0, coef_we}, 32'd0);
                check("tbl_err_status", status_out, {16'h1000, vecs[k].cnt});
                coef_ctrl[29] = ~coef_ctrl[29];
                tick();
                check("tbl_err_clear", status_out, {16'd0, vecs[k].cnt});
            end
        end

        // Randomized transactions against a transaction-level model.
        do_reset();
        m_bank = 0; m_count = 0; m_range = 0; m_over = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                int unsigned idx, d, base;
                idx = $urandom_range(0, 19);
                d = $urandom;
                coef_ctrl = {~coef_ctrl[31], coef_ctrl[30:8], 8'(idx)};
                coef_data = d;
                if (idx < NTAPS / 2) begin
                    base = (m_bank == 0 ? NTAPS : 0) + 2 * idx;
                    exp_q.push_back(W'(base * 65536 + (d >> 16)));
                    exp_q.push_back(W'((base + 1) * 65536 + (d & 32'hFFFF)));
                    m_count = (m_count + 1) % 65536;
                end else begin
                    m_range = 1;
                end
                tick();
                for (int g = 0; g < 8 && status_out[31]; g++) tick();
            end else if (kind < 8) begin
                int unsigned dly;
                dly = $urandom_range(0, 5);
                coef_ctrl[30] = ~coef_ctrl[30];
                tick();
                repeat (dly) tick();
                sync_in = 1'b1;
                tick();
                sync_in = 1'b0;
                m_bank ^= 1;
            end else if (kind == 8) begin
                coef_ctrl[29] = ~coef_ctrl[29];
                tick();
                m_range = 0;
                m_over = 0;
            end else begin
                for (int s = 0; s < 3; s++) begin
                    sync_in = 1'($urandom_range(0, 1));
                    tick();
                end
                sync_in = 1'b0;
            end
            check("rnd_status", status_out,
                  {2'b00, 1'(m_over), 1'(m_range), 12'd0, 16'(m_count)});
            check("rnd_bank", {31'd0, active_bank}, m_bank);
        end
        tick();
        mon_en = 1'b0;
        check("rnd_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter NTAPS, default 32: FIR taps per bank; even, power of two.
REQ-002 Parameter COEF_W, default 16: coefficient width; 2*COEF_W = 32.
REQ-003 user_clk  in  1  sole clock; all logic rising-edge.
REQ-004 user_rst_n  in  1  reset, synchronous, active-low.
REQ-005 coef_data  in  32  b0b1 software register value; [31:16]=b0 (even tap), [15:0]=b1 (odd tap).
REQ-006 coef_ctrl  in  32  control register; [31]=load toggle, [30]=commit toggle, [29]=clear-errors toggle, [7:0]=pair index.
REQ-007 sync_in  in  1  FIR frame-boundary pulse, one cycle.
REQ-008 coef_we  out  1  coefficient RAM write enable.
REQ-009 coef_addr  out  log2(NTAPS)+1  {bank, tap}.
REQ-010 coef_wdata  out  COEF_W  coefficient value.
REQ-011 active_bank  out  1  bank the FIR reads.
REQ-012 status_out  out  32  [31]=busy, [30]=commit_pending, [29]=overrun, [28]=range_err, [15:0]=load_count.

Function
REQ-013 Toggle event: bit differs from its registered copy; each event lasts one cycle.
REQ-014 First cycle after reset: copies load without generating events (arm cycle).
REQ-015 FSM states: IDLE, WR_B0, WR_B1, WAIT_SYNC.
REQ-016 IDLE + load event: latch coef_data and index; go to WR_B0 next cycle.
REQ-017 WR_B0: coef_we=1, coef_addr={~active_bank, 2*idx}, coef_wdata=b0; go to WR_B1.
REQ-018 WR_B1: coef_we=1, coef_addr={~active_bank, 2*idx+1}, coef_wdata=b1; load_count increments (wraps 0xFFFF->0); go to IDLE, or WAIT_SYNC if commit_pending.
REQ-019 Load-event-to-first-write latency: exactly 1 cycle; two consecutive write cycles.
REQ-020 idx >= NTAPS/2: no writes, range_err set, load_count unchanged, stay in IDLE.
REQ-021 Load event while in WR_B0/WR_B1/WAIT_SYNC: ignored, overrun set.
REQ-022 Commit event sets commit_pending; in IDLE, go to WAIT_SYNC next cycle.
REQ-023 Load and commit events in same IDLE cycle: load serviced first, commit pending, WAIT_SYNC after WR_B1.
REQ-024 WAIT_SYNC + sync_in: active_bank inverts next cycle, commit_pending cleared, go to IDLE.
REQ-025 sync_in in any other state: no effect.
REQ-026 Clear-errors event clears overrun and range_err; a same-cycle set wins.
REQ-027 busy=1 in any state other than IDLE.
REQ-028 coef_we=0 and coef_addr/coef_wdata hold previous values outside WR_B0/WR_B1.
REQ-029 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-030 On user_rst_n=0 at clock edge: FSM to IDLE.
REQ-031 Reset values: coef_we=0, coef_addr=0, coef_wdata=0, active_bank=0, flags=0, load_count=0.
REQ-032 Reset mid-write: the pending second write is abandoned and load_count is not incremented.
REQ-033 Reset mid-commit: commit_pending is cleared and no bank flip occurs.

Structure
REQ-034 A shared package holds the FSM state enum, status bit positions and ctrl bit positions.
REQ-035 One sub-module, toggle_detect: per-bit registered copy, arm cycle, event pulse.

Verification
REQ-036 Reset; ctrl=0x80000003, data=0x12345678 -> cycle+1: we, addr=0x26, wdata=0x1234; cycle+2: we, addr=0x27, wdata=0x5678; load_count=1.
REQ-037 Commit toggle; sync_in 10 cycles later -> busy for those cycles, active_bank=1 on the cycle after sync_in; following load writes addr bit5=0.
REQ-038 Load and commit toggled together (ctrl 0x00000000->0xC0000001) -> two writes to bank 1, then WAIT_SYNC; early sync_in during the writes is ignored.
REQ-039 Index 16 with NTAPS=32 -> no coef_we, status_out[28]=1; clear-errors toggle -> status_out[28]=0.
REQ-040 Second load toggle during WR_B0 -> only one write pair, overrun=1; reset asserted in WR_B0 -> next cycle coef_we=0 and load_count unchanged.
